seq_trend_chk: RTL and testbench
================================

Name: seq_trend_chk

Overview:
- Parametrised successor of the 4-bit sequence checker.
- Receives a variable-length burst of DATA_W-bit samples qualified by in_valid.
- Checks the burst against a runtime-selectable trend mode.
- Returns a one-cycle verdict with the burst length. Sits between the pattern driver and the scoring logic of the practice-lab datapath.

Parameters:
- DATA_W, 4, sample width in bits (2..16)
- MAX_LEN, 16, longest burst checked; longer bursts fail as overflow
- LEN_W, $clog2(MAX_LEN+1), width of out_len (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  high for every beat of a burst; a burst is one contiguous high run
- in_data  in  DATA_W  unsigned sample, valid when in_valid=1
- mode  in  2  trend mode, sampled only on first beat: 0 strictly increasing, 1 strictly decreasing, 2 non-decreasing, 3 all equal
- out_valid  out  1  one-cycle verdict strobe
- out_data  out  1  1 = burst matched mode and did not overflow; 0 otherwise
- out_len  out  LEN_W  beats received, saturating at MAX_LEN

Behaviour:
- Clock/reset: one clock clk; reset rst_n asynchronous, active-low. While rst_n=0: out_valid=0, out_data=0, out_len=0, FSM=IDLE, all internal registers 0.
- FSM states: IDLE, RECV, OUT.
- IDLE -> RECV on in_valid=1. On that edge: latch mode, latch in_data as prev, set cnt=1, set ok=1, set ovf=0.
- RECV, in_valid=1 (each further beat):
  - compare in_data against prev under the latched mode; clear ok on violation
  - update prev
  - cnt increments, saturating at MAX_LEN
  - if cnt already equals MAX_LEN when a beat arrives, set ovf=1
- RECV, in_valid=0 -> OUT.
- OUT, one cycle:
  - out_valid=1, out_data = ok & ~ovf, out_len = cnt
  - next state IDLE; outputs return to 0 on the following cycle
- Latency: verdict appears on the 2nd rising edge after the last beat, i.e. exactly one idle cycle after in_valid falls.
- Comparisons are unsigned at DATA_W bits. No wrap-around interpretation: 15 followed by 0 is a decrease.
- Single-beat burst: out_data=1, out_len=1, for every mode.
- Burst of exactly MAX_LEN beats: not overflow. MAX_LEN+1 beats: out_data=0, out_len=MAX_LEN.
- mode changes mid-burst are ignored. Only the first-beat value counts.
- in_valid=1 during OUT is ignored and does not start a burst. Protocol requires at least one idle cycle after in_valid falls; the bench guarantees it.
- Asynchronous reset mid-burst or during OUT aborts immediately. No verdict is produced for the aborted burst.
- out_data and out_len are 0 whenever out_valid=0.

Optional Feature:
- Macro: SEQ_FIRST_ERR_EN.
- Defined: adds output err_idx [LEN_W-1:0].
  - Holds the 0-based index of the first violating beat, qualified by out_valid.
  - Value 0 means no violation. Beat 0 can never violate.
  - On overflow with no earlier violation, err_idx = MAX_LEN.
  - Reset value 0; 0 whenever out_valid=0.
- Undefined: the port and its tracking register do not exist. All other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - enum state_t {IDLE, RECV, OUT}
  - enum mode_t {M_INC=0, M_DEC=1, M_NDEC=2, M_EQ=3}
  - localparam defaults DATA_W_DEF=4, MAX_LEN_DEF=16
- One sub-module, seq_trend_cmp: combinational, parameter DATA_W, inputs prev, cur, mode_t; output pass.
- The top keeps the FSM, counters and flags.

Test Plan:
- mode=0, burst 1,3,7,12 -> one cycle after in_valid falls: out_valid=1, out_data=1, out_len=4; err_idx=0.
- mode=1, burst 9,5,5,2 -> out_data=0, out_len=4 (5,5 is not strictly decreasing); err_idx=2. Same data with mode=2 -> out_data=0, err_idx=1.
- mode=3, 17 beats of value 6, MAX_LEN=16 -> out_data=0, out_len=16, err_idx=16. With 16 beats -> out_data=1, out_len=16.
- mode=2, single beat 0xF -> out_data=1, out_len=1. Then 15,0 under mode=0 -> out_data=0, err_idx=1 (no wrap).
- Assert rst_n=0 for 1 cycle after beat 3 of 6 -> no out_valid for that burst, all outputs 0. Next burst 2,4 under mode=0 -> out_data=1, out_len=2.
- Toggle mode every beat during burst 1,2,3 with first-beat mode=0 -> out_data=1. Drive in_valid=1 in the OUT cycle -> ignored, no new burst started.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the trend checker.
// States, trend modes and default sizing.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        OUT
    } state_t;

    typedef enum logic [1:0] {
        M_INC  = 2'd0,
        M_DEC  = 2'd1,
        M_NDEC = 2'd2,
        M_EQ   = 2'd3
    } mode_t;

    localparam int DATA_W_DEF  = 4;
    localparam int MAX_LEN_DEF = 16;

endpackage

// File: rtl/seq_trend_cmp.sv
// Single-step trend comparator: does cur follow prev under mode?
// Unsigned compare at DATA_W bits, no wrap-around.
module seq_trend_cmp
    import seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] cur,
    input  mode_t             mode,
    output logic              pass
);

    always_comb begin
        pass = 1'b0;
        unique case (mode)
            M_INC:   pass = (cur >  prev);
            M_DEC:   pass = (cur <  prev);
            M_NDEC:  pass = (cur >= prev);
            M_EQ:    pass = (cur == prev);
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_trend_chk.sv
// Burst trend checker: one-cycle verdict with burst length.
// Define SEQ_FIRST_ERR_EN to add the err_idx first-violation output.
module seq_trend_chk
    import seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    output logic              out_valid,
    output logic              out_data,
`ifdef SEQ_FIRST_ERR_EN
    output logic [LEN_W-1:0]  err_idx,
`endif
    output logic [LEN_W-1:0]  out_len
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              ok_q, ok_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              out_data_q, out_data_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;
`ifdef SEQ_FIRST_ERR_EN
    logic [LEN_W-1:0]  err_q, err_d;
    logic [LEN_W-1:0]  err_idx_q, err_idx_d;
`endif
    logic              pass;

    seq_trend_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .prev (prev_q),
        .cur  (in_data),
        .mode (mode_q),
        .pass (pass)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        ok_d        = ok_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_data_d  = 1'b0;
        out_len_d   = '0;
`ifdef SEQ_FIRST_ERR_EN
        err_d       = err_q;
        err_idx_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RECV;
                    mode_d  = mode_t'(mode);
                    prev_d  = in_data;
                    cnt_d   = ONE_L;
                    ok_d    = 1'b1;
                    ovf_d   = 1'b0;
`ifdef SEQ_FIRST_ERR_EN
                    err_d   = '0;
`endif
                end
            end
            RECV: begin
                if (in_valid) begin
                    prev_d = in_data;
                    if (!pass) ok_d = 1'b0;
                    if (cnt_q == MAX_L) ovf_d = 1'b1;
                    else cnt_d = cnt_q + ONE_L;
`ifdef SEQ_FIRST_ERR_EN
                    // cnt_q is the index of this beat, saturated at MAX_LEN
                    if (err_q == '0 && (!pass || cnt_q == MAX_L))
                        err_d = cnt_q;
`endif
                end else begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = ok_q & ~ovf_q;
                    out_len_d   = cnt_q;
`ifdef SEQ_FIRST_ERR_EN
                    err_idx_d   = err_q;
`endif
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= M_INC;
            prev_q      <= '0;
            cnt_q       <= '0;
            ok_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_len_q   <= '0;
`ifdef SEQ_FIRST_ERR_EN
            err_q       <= '0;
            err_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            ok_q        <= ok_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
`ifdef SEQ_FIRST_ERR_EN
            err_q       <= err_d;
            err_idx_q   <= err_idx_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
`ifdef SEQ_FIRST_ERR_EN
    assign err_idx   = err_idx_q;
`endif

endmodule

// File: tb/tb_seq_trend_chk.sv
// Self-checking bench for seq_trend_chk: directed cases then random bursts.
// Expected verdicts come from a list-based trend model.
module tb_seq_trend_chk;

    localparam int DW = 4;
    localparam int ML = 16;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    mode = 2'd0;
    logic          out_valid;
    logic          out_data;
    logic [LW-1:0] out_len;
`ifdef SEQ_FIRST_ERR_EN
    logic [LW-1:0] err_idx;
`endif

    int nerr = 0;
    int nchk = 0;

    seq_trend_chk #(
        .DATA_W  (DW),
        .MAX_LEN (ML)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef SEQ_FIRST_ERR_EN
        .err_idx   (err_idx),
`endif
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int m, input int q[$],
                                  output int ok, output int len,
                                  output int err);
        int n;
        int fv;
        bit good;
        n  = q.size();
        fv = -1;
        for (int i = 1; i < n; i++) begin
            case (m)
                0:       good = q[i] >  q[i-1];
                1:       good = q[i] <  q[i-1];
                2:       good = q[i] >= q[i-1];
                default: good = q[i] == q[i-1];
            endcase
            if (!good && fv < 0) fv = i;
        end
        ok  = (fv < 0 && n <= ML) ? 1 : 0;
        len = (n > ML) ? ML : n;
        if (fv >= 0)     err = (fv > ML) ? ML : fv;
        else if (n > ML) err = ML;
        else             err = 0;
    endfunction

    task automatic run(input string tag, input int m, input int q[$],
                       input bit tog, input bit poke);
        int eok, elen, eerr;
        model(m, q, eok, elen, eerr);
        foreach (q[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(q[i]);
            mode     = (tog && i > 0) ? 2'(m + i) : 2'(m);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"}, 32'(out_data), 32'(eok));
        chk({tag, ".len"}, 32'(out_len), 32'(elen));
`ifdef SEQ_FIRST_ERR_EN
        chk({tag, ".err"}, 32'(err_idx), 32'(eerr));
`endif
        if (poke) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            mode     = 2'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".post_v"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_d"}, 32'(out_data), 32'd0);
        chk({tag, ".post_l"}, 32'(out_len), 32'd0);
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk({tag, ".ghost"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        int q[$];
        int m, n, sty, v;

        #12;
        chk("rst_v", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(out_data), 32'd0);
        chk("rst_l", 32'(out_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("inc",    0, '{1, 3, 7, 12}, 1'b0, 1'b0);
        run("dec_eq", 1, '{9, 5, 5, 2}, 1'b0, 1'b0);
        run("ndec",   2, '{9, 5, 5, 2}, 1'b0, 1'b0);
        q = {};
        for (int i = 0; i < 17; i++) q.push_back(6);
        run("ovf17", 3, q, 1'b0, 1'b0);
        void'(q.pop_back());
        run("full16", 3, q, 1'b0, 1'b0);
        run("single", 2, '{15}, 1'b0, 1'b0);
        run("nowrap", 0, '{15, 0}, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            mode     = 2'd0;
        end
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort_v", 32'(out_valid), 32'd0);
        chk("abort_l", 32'(out_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_q", 32'(out_valid), 32'd0);
        end
        run("after_rst", 0, '{2, 4}, 1'b0, 1'b0);
        run("tog_mode",  0, '{1, 2, 3}, 1'b1, 1'b1);

        for (int r = 0; r < 40; r++) begin
            q   = {};
            n   = $urandom_range(1, 20);
            m   = $urandom_range(0, 3);
            sty = $urandom_range(0, 2);
            v   = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) begin
                if (sty == 0) v = $urandom_range(0, 15);
                else if (sty == 1) v = $urandom_range(0, 1);
                else if (i > 0) begin
                    case (m)
                        0:       v = v + $urandom_range(1, 2);
                        1:       v = v - $urandom_range(1, 2);
                        2:       v = v + $urandom_range(0, 1);
                        default: v = v;
                    endcase
                end
                v = v & 15;
                q.push_back(v);
            end
            run("rand", m, q, r[0], r[2]);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
